fp_addsub_scheduler: RTL and testbench
======================================

Name: fp_addsub_scheduler

Overview:
- Shares one pipelined IEEE-754 single-precision add/subtract unit among NUM_REQ requesters.
- Grants the unit round-robin, one operation per cycle, and carries a requester tag alongside the adder pipeline.
- Routes each result back to its originating requester with a one-cycle valid pulse.
- A start/drain/done sequence lets the top-level controller open a compute phase and learn when every issued operation has retired.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 6, adder cycles from operands presented to add_result valid, counted in cycles with add_ce=1.
- ID_W, 2, tag width; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  level; high opens a compute phase, low ends it.
- hold  in  1  freezes the adder pipeline and the tag pipeline.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant.
- req_a  in  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, same packing.
- req_op  in  NUM_REQ  per-requester op; 0=add, 1=subtract.
- add_a  out  32  operand A to the adder.
- add_b  out  32  operand B to the adder.
- add_op  out  1  op to the adder.
- add_ce  out  1  adder clock enable, active-high; the wrapper inverts it as needed.
- add_result  in  32  adder output.
- rsp_result  out  32  registered result.
- rsp_valid  out  NUM_REQ  one-hot result strobe.
- busy  out  1  one or more operations in flight.
- done  out  1  one-cycle pulse when a drain completes.

Behaviour:
- Reset: state=IDLE; every output 0; tag pipeline cleared; round-robin pointer set so requester 0 has top priority. Operations in flight at reset are discarded and never produce rsp_valid.
- FSM:
  - IDLE -> RUN when start=1.
  - RUN -> DRAIN when start=0.
  - DRAIN -> IDLE when the in-flight count is 0; done=1 on that transition cycle.
  - start=1 during DRAIN is ignored. It is sampled again in IDLE on the cycle after done.
- Grant:
  - req_ready is combinational and only asserts in RUN with hold=0.
  - Grant goes to the lowest index at or after (last_granted+1) mod NUM_REQ with req_valid=1.
  - At most one bit of req_ready is set. The pointer updates only when a transfer occurs.
  - A transfer is req_valid[i] & req_ready[i]. Requesters hold their operands until they see a transfer.
- Issue stage:
  - On a transfer, add_a, add_b and add_op are registered from requester i. Tag {valid=1, id=i} enters the tag pipeline.
  - Without a transfer, the tag valid bit is 0 and add_a/add_b are driven to 0.
- Tag pipeline:
  - LATENCY+1 stages, advancing only when hold=0.
  - add_ce = ~hold.
- Response:
  - When the tag at the pipeline tail is valid and hold=0, rsp_result <= add_result and rsp_valid <= onehot(id) on the next edge.
  - Otherwise rsp_valid <= 0 and rsp_result holds its value.
- Latency: handshake in cycle t gives rsp_valid in cycle t+LATENCY+2, plus one cycle for every hold=1 cycle in between. Throughput is one operation per non-held cycle.
- In-flight count:
  - Increments on a transfer and decrements when rsp_valid is set.
  - Simultaneous increment and decrement leave the count unchanged.
  - Range 0..LATENCY+2; busy = (count != 0).
- Simultaneous events:
  - start falling in the same cycle as a transfer: the transfer completes, because RUN is still current that cycle.
  - hold=1 with req_valid: no grant is given.
- No arithmetic is done in this block. Signed-zero normalisation and IEEE conversion belong to the adder wrapper.

Test Plan:
- Single op: requester 2, A=0x3F800000, B=0x40000000, op=0, handshake at t -> rsp_valid=4'b0100 at t+8, rsp_result=0x40400000 (LATENCY=6).
- Subtract: requester 0, A=0x40400000, B=0x3F800000, op=1 -> rsp_valid=4'b0001 with rsp_result=0x40000000.
- Fairness: all four requesters hold req_valid for 8 cycles -> grants in order 0,1,2,3,0,1,2,3. Responses come back in the same order on consecutive cycles.
- Hold: hold=1 for 3 cycles while 2 ops are in flight -> add_ce=0 and no grants during the hold. Each response arrives 3 cycles late with the correct requester id and value.
- Drain: start falls with 5 ops in flight -> busy stays 1 until the 5th rsp_valid, done pulses once, and the state returns to IDLE. start=1 during DRAIN is ignored.
- Reset mid-run: rst=1 with 4 ops in flight -> no rsp_valid afterwards, all outputs 0, and the next grant goes to requester 0.

Source files
------------

// File: rtl/fp_addsub_scheduler.sv
// Round-robin scheduler sharing one pipelined FP add/sub unit among NUM_REQ requesters.
// A tag pipeline follows each operation through the adder so results return to their requester.
module fp_addsub_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 6,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    hold,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]      req_op,
  output logic [31:0]             add_a,
  output logic [31:0]             add_b,
  output logic                    add_op,
  output logic                    add_ce,
  input  logic [31:0]             add_result,
  output logic [31:0]             rsp_result,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = $clog2(LATENCY + 3);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [ID_W-1:0]       last_reg;
  logic [ID_W-1:0]       grant_idx;
  logic                  grant_found;
  logic                  transfer;
  logic                  retire;
  logic [CNT_W-1:0]      count_reg;
  logic [31:0]           add_a_reg, add_b_reg;
  logic                  add_op_reg;
  logic [31:0]           rsp_result_reg;
  logic [NUM_REQ-1:0]    rsp_valid_reg;
  logic                  tag_valid_reg [LATENCY+1];
  logic [ID_W-1:0]       tag_id_reg    [LATENCY+1];
  logic [31:0]           a_arr [NUM_REQ];
  logic [31:0]           b_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[32*gi +: 32];
      assign b_arr[gi] = req_b[32*gi +: 32];
    end
  endgenerate

  // Search starts one past the last granted requester so every requester gets a turn.
  always_comb begin
    int idx;
    idx         = 0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_reg) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
    req_ready = '0;
    if (state_reg == RUN && !hold && grant_found)
      req_ready[grant_idx] = 1'b1;
  end

  assign transfer = |(req_valid & req_ready);
  assign retire   = tag_valid_reg[LATENCY] & ~hold;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (!start) state_next = DRAIN;
      DRAIN:   if (count_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done = (state_reg == DRAIN) && (count_reg == '0);
  end

  // Issue stage is frozen together with the adder while hold is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a_reg        <= '0;
      add_b_reg        <= '0;
      add_op_reg       <= 1'b0;
      last_reg         <= ID_W'(NUM_REQ - 1);
      tag_valid_reg[0] <= 1'b0;
      tag_id_reg[0]    <= '0;
    end else if (!hold) begin
      tag_valid_reg[0] <= transfer;
      tag_id_reg[0]    <= grant_idx;
      if (transfer) begin
        add_a_reg  <= a_arr[grant_idx];
        add_b_reg  <= b_arr[grant_idx];
        add_op_reg <= req_op[grant_idx];
        last_reg   <= grant_idx;
      end else begin
        add_a_reg  <= '0;
        add_b_reg  <= '0;
        add_op_reg <= 1'b0;
      end
    end
  end

  generate
    for (gi = 1; gi <= LATENCY; gi++) begin : g_tag
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_id_reg[gi]    <= '0;
        end else if (!hold) begin
          tag_valid_reg[gi] <= tag_valid_reg[gi-1];
          tag_id_reg[gi]    <= tag_id_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result_reg <= '0;
      rsp_valid_reg  <= '0;
      count_reg      <= '0;
    end else begin
      rsp_valid_reg <= '0;
      if (retire) begin
        rsp_result_reg <= add_result;
        rsp_valid_reg  <= NUM_REQ'(1) << tag_id_reg[LATENCY];
      end
      count_reg <= count_reg + CNT_W'(transfer) - CNT_W'(retire);
    end
  end

  assign add_a      = add_a_reg;
  assign add_b      = add_b_reg;
  assign add_op     = add_op_reg;
  assign add_ce     = ~hold;
  assign rsp_result = rsp_result_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign busy       = (count_reg != '0);

endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// Directed bench for fp_addsub_scheduler with a behavioural stand-in for the pipelined adder.
module tb_fp_addsub_scheduler;
  localparam int NR  = 4;
  localparam int LAT = 6;

  logic            clk, rst, start, hold;
  logic [NR-1:0]   req_valid, req_ready, req_op, rsp_valid;
  logic [32*NR-1:0] req_a, req_b;
  logic [31:0]     add_a, add_b, add_result, rsp_result;
  logic            add_op, add_ce, busy, done;

  fp_addsub_scheduler #(.NUM_REQ(NR), .LATENCY(LAT), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_ce(add_ce),
    .add_result(add_result), .rsp_result(rsp_result), .rsp_valid(rsp_valid),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in adder: two real IEEE cases, otherwise an easy-to-predict integer function.
  function automatic logic [31:0] amodel(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (a == 32'h3F800000 && b == 32'h40000000 && !op) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'h3F800000 && op)  return 32'h40000000;
    return op ? a + ~b : a + b;
  endfunction

  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    if (add_ce) begin
      pipe[0] <= amodel(add_a, add_b, add_op);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign add_result = pipe[LAT-1];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic op);
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_op[r] = op;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; hold = 1'b0; req_valid = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] exp);
    int t, n;
    set_req(r, a, b, op);
    req_valid = '0; req_valid[r] = 1'b1;
    n = 0; #1;
    while (!req_ready[r] && n < 20) begin tick(); #1; n++; end
    if (!req_ready[r]) chk("grant_timeout", 32'(req_ready), 32'(1 << r));
    t = cyc;
    tick(); req_valid = '0; n = 0; #1;
    while (rsp_valid == '0 && n < 20) begin tick(); #1; n++; end
    chk("latency", 32'(cyc - t), 32'd8);
    chk("rsp_id", 32'(rsp_valid), 32'(1 << r));
    chk("rsp_result", rsp_result, exp);
    $display("op req=%0d a=%08h b=%08h op=%0d -> valid=%b result=%08h lat=%0d",
             r, a, b, op, rsp_valid, rsp_result, cyc - t);
    tick();
  endtask

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int c0;
    logic [NR-1:0] ev;
    int ndone;
    vecs[0] = '{2, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
    vecs[1] = '{0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
    vecs[2] = '{1, 32'd10,       32'd20,       1'b0, 32'd30};
    vecs[3] = '{3, 32'd100,      32'd5,        1'b1, 32'd94};
    req_a = '0; req_b = '0; req_op = '0;
    do_reset();
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_rsp_result", rsp_result, 0);

    start = 1'b1; tick();
    foreach (vecs[i]) run_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);

    // Fairness: all requesters valid for 8 cycles.
    do_reset();
    start = 1'b1; tick();
    for (int i = 0; i < NR; i++) set_req(i, 32'h100 * (i + 1), 32'(i), i[0]);
    req_valid = '1;
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      #1; chk("fair_grant", 32'(req_ready), 32'(1 << (k % NR)));
      $display("fair cycle %0d grant=%b", k, req_ready);
      tick();
    end
    req_valid = '0;
    for (int c = 8; c < 17; c++) begin
      #1;
      ev = (c < 16) ? NR'(1 << ((c - 8) % NR)) : '0;
      chk("fair_rsp_id", 32'(rsp_valid), 32'(ev));
      if (ev != '0)
        chk("fair_rsp_result", rsp_result,
            amodel(32'h100 * ((c - 8) % NR + 1), 32'((c - 8) % NR), 1'((c - 8) % 2)));
      $display("fair rsp cycle %0d valid=%b result=%08h", c, rsp_valid, rsp_result);
      tick();
    end

    // Hold: two ops in flight, hold for three cycles.
    set_req(1, 32'd7, 32'd8, 1'b0);
    set_req(2, 32'd50, 32'd9, 1'b1);
    req_valid = 4'b0110;
    c0 = cyc;
    #1; chk("hold_grant1", 32'(req_ready), 32'b0010);
    tick(); req_valid = 4'b0100;
    #1; chk("hold_grant2", 32'(req_ready), 32'b0100);
    tick(); req_valid = '0;
    #1; chk("hold_busy", 32'(busy), 1);
    for (int c = 2; c < 15; c++) begin
      hold = (c >= 3 && c <= 5);
      req_valid = hold ? 4'b1000 : 4'b0000;
      #1;
      if (hold) begin
        chk("hold_add_ce", 32'(add_ce), 0);
        chk("hold_no_grant", 32'(req_ready), 0);
      end
      ev = (c == 11) ? 4'b0010 : (c == 12) ? 4'b0100 : 4'b0000;
      chk("hold_rsp_id", 32'(rsp_valid), 32'(ev));
      if (c == 11) chk("hold_rsp1", rsp_result, 32'd15);
      if (c == 12) chk("hold_rsp2", rsp_result, 32'd40);
      $display("hold cycle %0d hold=%0d ce=%0d valid=%b result=%08h", c, hold, add_ce, rsp_valid, rsp_result);
      tick();
    end
    hold = 1'b0; req_valid = '0;

    // Drain: five ops, start falls on the cycle of the fifth transfer.
    for (int i = 0; i < NR; i++) set_req(i, 32'd1000 + 32'(i), 32'd1, 1'b0);
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) start = 1'b0;
      #1; chk("drain_grant", 32'(req_ready), 32'(1 << ((3 + k) % NR)));
      tick();
    end
    req_valid = '0;
    ndone = 0;
    for (int c = 5; c < 16; c++) begin
      start = (c >= 6 && c <= 8);
      #1;
      case (c)
        8: ev = 4'b1000; 9: ev = 4'b0001; 10: ev = 4'b0010;
        11: ev = 4'b0100; 12: ev = 4'b1000; default: ev = 4'b0000;
      endcase
      chk("drain_rsp_id", 32'(rsp_valid), 32'(ev));
      if (ev != '0) chk("drain_rsp_result", rsp_result, 32'd1001 + 32'($clog2(ev)));
      chk("drain_busy", 32'(busy), 32'(c < 12));
      chk("drain_done", 32'(done), 32'(c == 12));
      if (done) ndone++;
      $display("drain cycle %0d start=%0d valid=%b busy=%0d done=%0d", c, start, rsp_valid, busy, done);
      tick();
    end
    chk("drain_done_count", 32'(ndone), 1);
    start = 1'b0;
    req_valid = '1; #1;
    chk("idle_no_grant", 32'(req_ready), 0);

    // Reset with four ops in flight.
    tick(); start = 1'b1; tick();
    for (int k = 0; k < 4; k++) tick();
    do_reset();
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_add_a", add_a, 0);
    chk("mid_rst_add_b", add_b, 0);
    chk("mid_rst_result", rsp_result, 0);
    for (int c = 0; c < 12; c++) begin
      chk("mid_rst_no_rsp", 32'(rsp_valid), 0);
      tick();
    end
    start = 1'b1; req_valid = '1; tick();
    #1; chk("mid_rst_next_grant", 32'(req_ready), 32'b0001);
    $display("post-reset grant=%b", req_ready);
    req_valid = '0; start = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
